// File: rtl/logic_bist_checker_pkg.sv
// Shared definitions for the logic BIST checker: default sizes, op codes and FSM states.
package logic_bist_checker_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/logic_bist_checker_if.sv
// Response-vector stream plus session status bundle between a driver and the BIST checker.
interface logic_bist_checker_if
  import logic_bist_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_idx;
  logic [WIDTH-1:0] first_err_exp;
  logic [WIDTH-1:0] first_err_got;

  modport master (
    output start, in_valid, in_last, op, a, b, y,
    input  in_ready, busy, done, pass, vec_count, err_count,
           first_err_idx, first_err_exp, first_err_got
  );

  modport slave (
    input  start, in_valid, in_last, op, a, b, y,
    output in_ready, busy, done, pass, vec_count, err_count,
           first_err_idx, first_err_exp, first_err_got
  );

endinterface

// File: rtl/logic_bist_checker_ref_model.sv
// Golden combinational model of the bitwise logic unit under test.
module logic_ref_model
  import logic_bist_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] exp_o
);

  always_comb begin
    exp_o = '0;
    case (op_i)
      OP_AND: exp_o = a_i & b_i;
      OP_OR:  exp_o = a_i | b_i;
      OP_XOR: exp_o = a_i ^ b_i;
      OP_NOR: exp_o = ~(a_i | b_i);
      default: exp_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_bist_checker.sv
// Session-based checker: registers each accepted vector, compares it against the
// reference model one cycle later and keeps saturating counts plus the first mismatch.
module logic_bist_checker
  import logic_bist_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  logic_bist_checker_if.slave bus
);

  state_e           state_q, state_d;
  logic             accept;
  logic             startSession;
  logic             mismatch;
  logic [WIDTH-1:0] expVal;

  logic             pipeValid_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] vecCount_q;
  logic [CNT_W-1:0] errCount_q;
  logic [CNT_W-1:0] firstIdx_q;
  logic [WIDTH-1:0] firstExp_q;
  logic [WIDTH-1:0] firstGot_q;

  assign accept       = bus.in_valid && (state_q == ST_RUN);
  assign startSession = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch     = (expVal != y_q);

  logic_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .exp_o (expVal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (accept && bus.in_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  if (bus.start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready      = (state_q == ST_RUN);
    bus.busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    bus.done          = (state_q == ST_DONE);
    bus.pass          = (state_q == ST_DONE) && (errCount_q == '0);
    bus.vec_count     = vecCount_q;
    bus.err_count     = errCount_q;
    bus.first_err_idx = firstIdx_q;
    bus.first_err_exp = firstExp_q;
    bus.first_err_got = firstGot_q;
  end

  // Counts never wrap, so errCount_q == 0 reliably marks "no mismatch captured yet".
  always_ff @(posedge clk) begin
    if (rst || startSession) begin
      pipeValid_q <= 1'b0;
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      vecCount_q  <= '0;
      errCount_q  <= '0;
      firstIdx_q  <= '0;
      firstExp_q  <= '0;
      firstGot_q  <= '0;
    end else begin
      pipeValid_q <= accept;
      if (accept) begin
        op_q <= op_e'(bus.op);
        a_q  <= bus.a;
        b_q  <= bus.b;
        y_q  <= bus.y;
      end
      if (pipeValid_q) begin
        if (vecCount_q != '1) begin
          vecCount_q <= vecCount_q + CNT_W'(1);
        end
        if (mismatch) begin
          if (errCount_q != '1) begin
            errCount_q <= errCount_q + CNT_W'(1);
          end
          if (errCount_q == '0) begin
            firstIdx_q <= vecCount_q;
            firstExp_q <= expVal;
            firstGot_q <= y_q;
          end
        end
      end
    end
  end

endmodule

// File: doc/logic_bist_checker.md
LOGIC_BIST_CHECKER -- requirements
Module: logic_bist_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the operand/result width.
REQ-002 The module SHALL have parameter CNT_W, default 16, the width of all counters and indices.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 The module SHALL have clk input 1: the single rising-edge clock.
REQ-005 The module SHALL have rst input 1: synchronous active-high reset.
REQ-006 The module SHALL have start input 1: a pulse that opens a check session.
REQ-007 The module SHALL have in_valid input 1: a response vector is present.
REQ-008 The module SHALL have in_ready output 1: the checker accepts a vector this cycle.
REQ-009 The module SHALL have in_last input 1: the vector is the final one of the session.
REQ-010 The module SHALL have op input 2: the operation code (00 AND, 01 OR, 10 XOR, 11 NOR).
REQ-011 The module SHALL have a, b inputs WIDTH: the operands applied to the unit under test.
REQ-012 The module SHALL have y input WIDTH: the result returned by the unit under test.
REQ-013 The module SHALL have busy output 1: a session is in progress.
REQ-014 The module SHALL have done output 1: the session is complete and the results are valid.
REQ-015 The module SHALL have pass output 1: done with err_count==0.
REQ-016 The module SHALL have vec_count output CNT_W: the number of vectors checked.
REQ-017 The module SHALL have err_count output CNT_W: the number of mismatching vectors.
REQ-018 The module SHALL have first_err_idx output CNT_W: the index (0-based) of the first mismatch.
REQ-019 The module SHALL have first_err_exp and first_err_got outputs WIDTH: the expected and received values at the first mismatch.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-021 IDLE->RUN SHALL occur on start; the same edge SHALL clear all counters and capture registers.
REQ-022 in_ready SHALL be 1 only in RUN; an accept is in_valid & in_ready.
REQ-023 On accept, {op,a,b,y} SHALL be registered; the expected value SHALL be computed from the registered op/a/b; the compare, vec_count increment and error capture SHALL occur on the next edge (1-cycle latency).
REQ-024 Back-to-back accepts SHALL be supported at one vector per cycle, with no bubbles.
REQ-025 An accept with in_last=1 SHALL move RUN->DRAIN; DRAIN SHALL retire the final compare and move to DONE on the following edge.
REQ-026 In DONE, done SHALL be 1 and pass SHALL be (err_count==0); busy SHALL be 1 only in RUN and DRAIN.
REQ-027 On the first mismatch of a session, first_err_idx/exp/got SHALL be loaded; later mismatches SHALL NOT overwrite them.
REQ-028 vec_count and err_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-029 start SHALL be ignored in RUN and DRAIN; in DONE, start SHALL clear the results and enter RUN (a new session).
REQ-030 in_valid in IDLE or DONE SHALL be ignored and SHALL NOT be counted.
REQ-031 A session with no mismatches SHALL leave first_err_* at 0.

Reset
REQ-032 rst SHALL force IDLE, with in_ready, busy, done, pass, counters and first_err_* all 0, and the pipeline valid bit cleared.
REQ-033 rst mid-session SHALL discard the in-flight vector; rst SHALL have priority over start.

Structure
REQ-034 The op encodings, the FSM state encodings and the default WIDTH/CNT_W values SHALL be placed in a shared package.
REQ-035 The expected-value logic SHALL be one combinational sub-module, logic_ref_model (op, a, b -> exp).

Verification
REQ-036 Reset then start, then XOR a=0xF0, b=0xFF, y=0x0F with last -> done 2 cycles after the accept, pass=1, vec_count=1, err_count=0.
REQ-037 Four back-to-back vectors (AND/OR/XOR/NOR of 0xFFFFFFFF, 0xAAAAAAAA) with correct y -> in_ready held at 1, vec_count=4, pass=1.
REQ-038 XOR of 0xFF, 0xAA with y=0x00 as vector 2 and a bad vector 3 -> err_count=2, first_err_idx=2, first_err_exp=0x55, first_err_got=0x00, pass=0.
REQ-039 rst asserted in RUN after 2 accepts -> next cycle IDLE with all outputs 0; in_valid ignored until start.
REQ-040 start held during RUN, and in_valid in IDLE -> no effect on state or counts; start in DONE -> counters cleared, RUN.
REQ-041 Preset counters near all-ones (CNT_W=4, 20 bad vectors) -> vec_count=err_count=15, no wrap.
